// File: rtl/riscv_perf_counters_if.sv
// rtl/riscv_perf_counters_if.sv - CSR access bus between the core and the perf counters
//
// Purpose: groups the CSR request/response signals shared by the core CSR
// file and the performance-monitor unit.
// Signals:
//   csr_access_i  CSR access valid this cycle
//   csr_addr_i    12-bit CSR address
//   csr_wdata_i   32-bit write operand
//   csr_op_i      0 NONE, 1 WRITE, 2 SET, 3 CLEAR
//   csr_rdata_o   read data, 0 when not hit
//   csr_hit_o     access maps to the perf-counter block
// Modports: master (core side), slave (perf-counter side).

interface riscv_perf_counters_if;
  logic        csr_access_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;

  modport master (
    output csr_access_i, csr_addr_i, csr_wdata_i, csr_op_i,
    input  csr_rdata_o, csr_hit_o
  );

  modport slave (
    input  csr_access_i, csr_addr_i, csr_wdata_i, csr_op_i,
    output csr_rdata_o, csr_hit_o
  );
endinterface

// File: rtl/riscv_perf_counters.sv
// rtl/riscv_perf_counters.sv - hardware performance-monitor counters for the RI5CY core
//
// Purpose: N_CNT event counters of CNT_WIDTH bits with per-counter event
// select, enable, saturate and (optional) overflow interrupt enable, plus a
// sticky overflow status register, all reachable through the CSR bus.
// Optional feature macro: PERF_OVF_IRQ_EN (registered overflow interrupt and
// stored CTRL irq_en bit); without it irq_o is tied 0 and CTRL[10] reads 0.
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   csr       CSR bus (slave modport): access/addr/wdata/op in, rdata/hit out
//   events_i  per-cycle event pulses, bit 0 is the cycle event
//   freeze_i  debug halt, blocks all increments
//   irq_o     overflow interrupt request (level)

module riscv_perf_counters #(
  parameter int N_EVENTS  = 16,
  parameter int N_CNT     = 4,
  parameter int CNT_WIDTH = 48
) (
  input  logic                      clk,
  input  logic                      rst_n,
  riscv_perf_counters_if.slave      csr,
  input  logic [N_EVENTS-1:0]       events_i,
  input  logic                      freeze_i,
  output logic                      irq_o
);

  localparam logic [1:0]  CSR_OP_NONE  = 2'd0;
  localparam logic [1:0]  CSR_OP_WRITE = 2'd1;
  localparam logic [1:0]  CSR_OP_SET   = 2'd2;
  localparam logic [1:0]  CSR_OP_CLEAR = 2'd3;

  localparam logic [11:0] ADDR_CNT_LO  = 12'hB03;
  localparam logic [11:0] ADDR_CNT_HI  = 12'hB83;
  localparam logic [11:0] ADDR_CTRL    = 12'h323;
  localparam logic [11:0] ADDR_OVF     = 12'h7A2;

  // State
  logic [CNT_WIDTH-1:0] r_cnt [N_CNT];
  logic [4:0]           r_sel [N_CNT];
  logic [N_CNT-1:0]     r_en;
  logic [N_CNT-1:0]     r_sat;
  logic [N_CNT-1:0]     r_ovf;
  logic [N_EVENTS-1:0]  r_ev_q;
  logic                 r_freeze_q;

  // Decode / datapath
  logic [N_CNT-1:0]     w_sel_lo;
  logic [N_CNT-1:0]     w_sel_hi;
  logic [N_CNT-1:0]     w_sel_ctrl;
  logic                 w_sel_ovf;
  logic                 w_hit;
  logic                 w_we;
  logic [31:0]          w_rdata;
  logic [31:0]          w_wdata;
  logic [63:0]          w_cnt_ext [N_CNT];
  logic [31:0]          w_ctrl_rd [N_CNT];
  logic [31:0]          w_ev_ext;
  logic [N_CNT-1:0]     w_inc;
  logic [N_CNT-1:0]     w_wr_cnt;
  logic [N_CNT-1:0]     w_ovf_set;
  logic [N_CNT-1:0]     w_irqen;

  // Zero-extended events: selector values >= N_EVENTS land on 0 bits.
  assign w_ev_ext = 32'(r_ev_q);

  assign w_sel_ovf = csr.csr_access_i && (csr.csr_addr_i == ADDR_OVF);

  for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
    assign w_sel_lo[i]   = csr.csr_access_i && (csr.csr_addr_i == ADDR_CNT_LO + 12'(i));
    assign w_sel_hi[i]   = csr.csr_access_i && (csr.csr_addr_i == ADDR_CNT_HI + 12'(i));
    assign w_sel_ctrl[i] = csr.csr_access_i && (csr.csr_addr_i == ADDR_CTRL + 12'(i));
    assign w_cnt_ext[i]  = 64'(r_cnt[i]);
    assign w_ctrl_rd[i]  = {21'd0, w_irqen[i], r_sat[i], r_en[i], 3'd0, r_sel[i]};
    assign w_inc[i]      = w_ev_ext[r_sel[i]] & r_en[i] & ~r_freeze_q;
    // A CSR write to either half drops the increment, so it cannot overflow either.
    assign w_wr_cnt[i]   = w_we & (w_sel_lo[i] | w_sel_hi[i]);
    assign w_ovf_set[i]  = w_inc[i] & ~w_wr_cnt[i] & (&r_cnt[i]);
  end

  assign w_hit = (|w_sel_lo) | (|w_sel_hi) | (|w_sel_ctrl) | w_sel_ovf;
  assign w_we  = w_hit && (csr.csr_op_i != CSR_OP_NONE);

  // Select vectors already include csr_access_i, so unmapped reads yield 0.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (w_sel_lo[i])   w_rdata = w_cnt_ext[i][31:0];
      if (w_sel_hi[i])   w_rdata = w_cnt_ext[i][63:32];
      if (w_sel_ctrl[i]) w_rdata = w_ctrl_rd[i];
    end
    if (w_sel_ovf) w_rdata = 32'(r_ovf);
  end

  always_comb begin
    w_wdata = w_rdata;
    case (csr.csr_op_i)
      CSR_OP_WRITE: w_wdata = csr.csr_wdata_i;
      CSR_OP_SET:   w_wdata = w_rdata | csr.csr_wdata_i;
      CSR_OP_CLEAR: w_wdata = w_rdata & ~csr.csr_wdata_i;
      default:      w_wdata = w_rdata;
    endcase
  end

  assign csr.csr_rdata_o = w_rdata;
  assign csr.csr_hit_o   = w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ev_q     <= '0;
      r_freeze_q <= 1'b0;
      r_ovf      <= '0;
      r_en       <= '0;
      r_sat      <= '0;
      for (int i = 0; i < N_CNT; i++) begin
        r_cnt[i] <= '0;
        r_sel[i] <= '0;
      end
    end else begin
      r_ev_q     <= events_i;
      r_freeze_q <= freeze_i;
      for (int i = 0; i < N_CNT; i++) begin
        if (w_we && w_sel_ctrl[i]) begin
          r_sel[i] <= w_wdata[4:0];
          r_en[i]  <= w_wdata[8];
          r_sat[i] <= w_wdata[9];
        end
        if (w_we && w_sel_lo[i]) begin
          r_cnt[i][31:0] <= w_wdata;
        end else if (w_we && w_sel_hi[i]) begin
          r_cnt[i][CNT_WIDTH-1:32] <= w_wdata[CNT_WIDTH-33:0];
        end else if (w_inc[i]) begin
          if (!(&r_cnt[i])) begin
            r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
          end else if (!r_sat[i]) begin
            r_cnt[i] <= '0;
          end
        end
      end
      // Hardware set is OR-ed in last so it beats a same-cycle software clear.
      if (w_we && w_sel_ovf) begin
        r_ovf <= w_wdata[N_CNT-1:0] | w_ovf_set;
      end else begin
        r_ovf <= r_ovf | w_ovf_set;
      end
    end
  end

`ifdef PERF_OVF_IRQ_EN
  logic [N_CNT-1:0] r_irqen;
  logic             r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irqen <= '0;
      r_irq   <= 1'b0;
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        if (w_we && w_sel_ctrl[i]) r_irqen[i] <= w_wdata[10];
      end
      r_irq <= |(r_ovf & r_irqen);
    end
  end

  assign w_irqen = r_irqen;
  assign irq_o   = r_irq;
`else
  assign w_irqen = '0;
  assign irq_o   = 1'b0;
`endif

endmodule
